// File: rtl/time_setter.sv
// Time-set controller: captures the running time, steps hour then minute with
// inc/dec buttons (hold to auto-repeat), and commits with a one-cycle load strobe.
module time_setter #(
    parameter int HOLD_CYCLES    = 50,
    parameter int REPEAT_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic [7:0] countHr,
    input  logic [7:0] countMin,
    output logic [7:0] setHour,
    output logic [7:0] setMin,
    output logic       load,
    output logic       abort,
    output logic       setting,
    output logic       field
);

    typedef enum logic [1:0] {ST_IDLE, ST_SET_HR, ST_SET_MIN, ST_COMMIT} state_t;

    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] HOLD_RELD  = 16'(HOLD_CYCLES - REPEAT_CYCLES);
    localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  HR_MAX     = 8'd23;
    localparam logic [7:0]  MIN_MAX    = 8'd59;

    state_t      r_state, w_next_state;
    logic        r_mode_q, r_inc_q, r_dec_q;
    logic [15:0] r_hold_cnt, w_hold_nxt;
    logic [15:0] r_idle_cnt, w_idle_nxt;
    logic        r_rep_en, w_rep_nxt;
    logic [7:0]  r_set_hour, r_set_min, w_hour_nxt, w_min_nxt;
    logic        r_load, r_abort, r_setting, r_field;

    logic w_mode_rise, w_inc_rise, w_dec_rise, w_any_rise;
    logic w_in_set, w_inc_only, w_dec_only;
    logic w_up, w_dn, w_step, w_timeout;

    function automatic logic [7:0] f_inc_wrap(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] f_dec_wrap(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'd0) ? max : v - 8'd1;
    endfunction

    function automatic logic [7:0] f_capture(input logic [7:0] v, input logic [7:0] max);
        return (v > max) ? 8'd0 : v;
    endfunction

    assign w_mode_rise = mode_btn & ~r_mode_q;
    assign w_inc_rise  = inc_btn & ~r_inc_q;
    assign w_dec_rise  = dec_btn & ~r_dec_q;
    assign w_any_rise  = w_mode_rise | w_inc_rise | w_dec_rise;
    assign w_in_set    = (r_state == ST_SET_HR) || (r_state == ST_SET_MIN);
    assign w_inc_only  = inc_btn & ~dec_btn;
    assign w_dec_only  = dec_btn & ~inc_btn;

    // Auto-repeat is armed only by a single-button rise; pressing both disarms it.
    always_comb begin
        w_up       = 1'b0;
        w_dn       = 1'b0;
        w_hold_nxt = 16'd0;
        w_rep_nxt  = 1'b0;
        if (w_in_set && (w_inc_only || w_dec_only)) begin
            if ((w_inc_only && w_inc_rise) || (w_dec_only && w_dec_rise)) begin
                w_up      = w_inc_only;
                w_dn      = w_dec_only;
                w_rep_nxt = 1'b1;
            end else if (r_rep_en) begin
                w_rep_nxt = 1'b1;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_up       = w_inc_only;
                    w_dn       = w_dec_only;
                    w_hold_nxt = HOLD_RELD;
                end else begin
                    w_hold_nxt = r_hold_cnt + 16'd1;
                end
            end
        end
    end

    assign w_step    = w_in_set & ~w_mode_rise & (w_up | w_dn);
    assign w_timeout = w_in_set & ~w_mode_rise & ~w_step & ~w_any_rise
                       & (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_mode_rise) w_next_state = ST_SET_HR;
            ST_SET_HR:  if (w_mode_rise) w_next_state = ST_SET_MIN;
                        else if (w_timeout) w_next_state = ST_IDLE;
            ST_SET_MIN: if (w_mode_rise) w_next_state = ST_COMMIT;
                        else if (w_timeout) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_hour_nxt = r_set_hour;
        w_min_nxt  = r_set_min;
        if (r_state == ST_IDLE && w_mode_rise) begin
            w_hour_nxt = f_capture(countHr, HR_MAX);
            w_min_nxt  = f_capture(countMin, MIN_MAX);
        end else if (w_step && r_state == ST_SET_HR) begin
            w_hour_nxt = w_up ? f_inc_wrap(r_set_hour, HR_MAX) : f_dec_wrap(r_set_hour, HR_MAX);
        end else if (w_step && r_state == ST_SET_MIN) begin
            w_min_nxt  = w_up ? f_inc_wrap(r_set_min, MIN_MAX) : f_dec_wrap(r_set_min, MIN_MAX);
        end

        w_idle_nxt = 16'd0;
        if (w_in_set && !w_any_rise && !w_step && !w_timeout)
            w_idle_nxt = r_idle_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q   <= 1'b0;
            r_inc_q    <= 1'b0;
            r_dec_q    <= 1'b0;
            r_hold_cnt <= 16'd0;
            r_idle_cnt <= 16'd0;
            r_rep_en   <= 1'b0;
            r_set_hour <= 8'd0;
            r_set_min  <= 8'd0;
            r_load     <= 1'b0;
            r_abort    <= 1'b0;
            r_setting  <= 1'b0;
            r_field    <= 1'b0;
        end else begin
            r_mode_q   <= mode_btn;
            r_inc_q    <= inc_btn;
            r_dec_q    <= dec_btn;
            r_hold_cnt <= w_hold_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_rep_en   <= w_rep_nxt;
            r_set_hour <= w_hour_nxt;
            r_set_min  <= w_min_nxt;
            r_load     <= (w_next_state == ST_COMMIT);
            r_abort    <= w_timeout;
            r_setting  <= (w_next_state == ST_SET_HR) || (w_next_state == ST_SET_MIN);
            r_field    <= (w_next_state == ST_SET_MIN);
        end
    end

    assign setHour = r_set_hour;
    assign setMin  = r_set_min;
    assign load    = r_load;
    assign abort   = r_abort;
    assign setting = r_setting;
    assign field   = r_field;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: expected load/abort events are queued when
// stimulus is driven and compared when the DUT strobes load or abort.
module tb_time_setter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
    logic [7:0] countHr = 8'd0, countMin = 8'd0;
    logic [7:0] setHour, setMin;
    logic       load, abort, setting, field;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        bit is_abort;
        int hr;
        int mn;
    } exp_t;
    exp_t sb[$];

    time_setter #(.HOLD_CYCLES(50), .REPEAT_CYCLES(10), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset),
        .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .countHr(countHr), .countMin(countMin),
        .setHour(setHour), .setMin(setMin),
        .load(load), .abort(abort), .setting(setting), .field(field)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0; tick();
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; tick(); inc_btn = 1'b0; tick();
    endtask

    task automatic press_dec();
        dec_btn = 1'b1; tick(); dec_btn = 1'b0; tick();
    endtask

    task automatic expect_load(input int hr, input int mn);
        exp_t e;
        e.is_abort = 1'b0; e.hr = hr; e.mn = mn;
        sb.push_back(e);
    endtask

    // Every load/abort strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (load === 1'b1 || abort === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("sb_unexpected", {30'd0, load, abort}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("ev_load", load, e.is_abort ? 32'd0 : 32'd1);
                check_val("ev_abort", abort, e.is_abort ? 32'd1 : 32'd0);
                check_val("ev_hour", setHour, e.hr);
                check_val("ev_min", setMin, e.mn);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        exp_t ea;

        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check_val("rst_hour", setHour, 0);
        check_val("rst_min", setMin, 0);
        check_val("rst_setting", setting, 0);
        check_val("rst_field", field, 0);
        check_val("rst_load", load, 0);
        check_val("rst_abort", abort, 0);

        // Capture 10:30, +2 hours, -1 minute.
        countHr = 8'd10; countMin = 8'd30;
        press_inc();
        check_val("idle_ignore_inc", setHour, 0);
        press_mode();
        check_val("cap_setting", setting, 1);
        check_val("cap_field", field, 0);
        check_val("cap_hour", setHour, 10);
        check_val("cap_min", setMin, 30);
        press_inc(); press_inc();
        check_val("inc_hour", setHour, 12);
        press_mode();
        check_val("min_field", field, 1);
        press_dec();
        check_val("dec_min", setMin, 29);
        expect_load(12, 29);
        press_mode();
        check_val("commit_setting", setting, 0);
        check_val("hold_hour", setHour, 12);

        // Upward wrap.
        countHr = 8'd23; countMin = 8'd59;
        press_mode(); press_inc(); press_mode(); press_inc();
        expect_load(0, 0);
        press_mode();

        // Downward wrap.
        countHr = 8'd0; countMin = 8'd0;
        press_mode(); press_dec(); press_mode(); press_dec();
        expect_load(23, 59);
        press_mode();

        // Out-of-range capture.
        countHr = 8'd30; countMin = 8'd70;
        press_mode();
        check_val("oor_hour", setHour, 0);
        check_val("oor_min", setMin, 0);
        press_mode();
        expect_load(0, 0);
        press_mode();

        // Auto-repeat: steps at press, +50, +60, +70.
        countHr = 8'd5; countMin = 8'd0;
        press_mode(); press_mode();
        inc_btn = 1'b1;
        for (int i = 0; i < 75; i++) begin
            tick();
            if (i == 0)  check_val("rep_first", setMin, 1);
            if (i == 49) check_val("rep_before_hold", setMin, 1);
            if (i == 50) check_val("rep_second", setMin, 2);
            if (i == 59) check_val("rep_before_third", setMin, 2);
        end
        inc_btn = 1'b0; tick();
        check_val("rep_total", setMin, 4);
        expect_load(5, 4);
        press_mode();

        // Both buttons held: no step, and no repeat after one is released.
        countHr = 8'd7; countMin = 8'd15;
        press_mode();
        inc_btn = 1'b1; dec_btn = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check_val("both_hour", setHour, 7);
        dec_btn = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check_val("both_no_rearm", setHour, 7);
        inc_btn = 1'b0; tick();
        press_mode();
        expect_load(7, 15);
        press_mode();

        // Timeout abort after 1000 idle cycles in SET_HR.
        countHr = 8'd3; countMin = 8'd4;
        ea.is_abort = 1'b1; ea.hr = 3; ea.mn = 4;
        sb.push_back(ea);
        press_mode();
        cnt = 0;
        while (setting === 1'b1 && cnt < 1100) begin
            tick();
            cnt++;
        end
        check_val("to_cycles", cnt, 999);
        check_val("to_abort_hi", abort, 1);
        check_val("to_no_load", load, 0);
        tick();
        check_val("to_abort_lo", abort, 0);
        check_val("to_keep_hour", setHour, 3);

        // Reset mid-session in SET_MIN.
        countHr = 8'd9; countMin = 8'd9;
        press_mode(); press_mode(); press_inc();
        check_val("pre_rst_min", setMin, 10);
        reset = 1'b1; tick(); reset = 1'b0;
        check_val("mrst_hour", setHour, 0);
        check_val("mrst_min", setMin, 0);
        check_val("mrst_setting", setting, 0);
        check_val("mrst_field", field, 0);
        check_val("mrst_load", load, 0);
        check_val("mrst_abort", abort, 0);
        tick();
        check_val("mrst_still_idle", setting, 0);
        countHr = 8'd1; countMin = 8'd2;
        press_mode();
        check_val("fresh_setting", setting, 1);
        check_val("fresh_field", field, 0);
        check_val("fresh_hour", setHour, 1);
        check_val("fresh_min", setMin, 2);
        press_mode();
        expect_load(1, 2);
        press_mode();

        tick(); tick();
        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
